// File: rtl/accel_csum_scan.sv
// -----------------------------------------------------------------------------
// accel_csum_scan
// Multi-channel Internet checksum (RFC 1071) accelerator for the core's
// accelerator slot. The core programs each channel over the io bus with a
// byte address and a length. The channel then streams packet lines from
// accelerator memory port b1 and posts the 16-bit ones-complement checksum in
// its RESULT register.
//
// Optional build macro: ACCEL_CSUM_PERF_EN adds a per-channel 32-bit CYCLES
// counter at offset 0x10. Without it, that offset reads 0.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   io_en/io_wen        io access strobe, 1=write 0=read
//   io_strb/io_addr     write byte enables, byte address in accel window
//   io_wr_data          write data
//   io_rd_data          registered read data
//   io_rd_valid         high one cycle after an accepted read
//   acc_*_b1            packet-memory read port. One read per cycle, with
//                       data returned one cycle after acc_en_b1.
//   acc_*_b2            reserved port. Outputs are tied to 0 and inputs ignored.
//
// Register map (channel = io_addr[5 +: log2(ACC_CHANNELS)], reg = io_addr[4:2])
//   0x00 ADDR   byte address (line aligned)   0x04 LEN    [15:0] bytes
//   0x08 CTRL   wr bit0 start / rd bit0 busy, bit1 done
//   0x0C RESULT [15:0] checksum              0x10 CYCLES (perf build only)
//
// The default PMEM_ADDR_WIDTH is 18. With 16-byte lines and 4096 lines per
// block, that width leaves exactly one block-select bit, which gives two
// blocks.
// -----------------------------------------------------------------------------
module accel_csum_scan #(
    parameter int DATA_WIDTH      = 128,
    parameter int STRB_WIDTH      = DATA_WIDTH/8,
    parameter int PMEM_ADDR_WIDTH = 18,
    parameter int SLOW_M_B_LINES  = 4096,
    parameter int ACC_ADDR_WIDTH  = $clog2(SLOW_M_B_LINES),
    parameter int PMEM_SEL_BITS   = PMEM_ADDR_WIDTH-$clog2(STRB_WIDTH)-1-ACC_ADDR_WIDTH,
    parameter int ACC_MEM_BLOCKS  = 2**PMEM_SEL_BITS,
    parameter int ACC_CHANNELS    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   io_en,
    input  logic                                   io_wen,
    input  logic [3:0]                             io_strb,
    input  logic [21:0]                            io_addr,
    input  logic [31:0]                            io_wr_data,
    output logic [31:0]                            io_rd_data,
    output logic                                   io_rd_valid,
    output logic [ACC_MEM_BLOCKS-1:0]              acc_en_b1,
    output logic [ACC_MEM_BLOCKS*STRB_WIDTH-1:0]   acc_wen_b1,
    output logic [ACC_MEM_BLOCKS*ACC_ADDR_WIDTH-1:0] acc_addr_b1,
    output logic [ACC_MEM_BLOCKS*DATA_WIDTH-1:0]   acc_wr_data_b1,
    input  logic [ACC_MEM_BLOCKS*DATA_WIDTH-1:0]   acc_rd_data_b1,
    output logic [ACC_MEM_BLOCKS-1:0]              acc_en_b2,
    output logic [ACC_MEM_BLOCKS*STRB_WIDTH-1:0]   acc_wen_b2,
    output logic [ACC_MEM_BLOCKS*ACC_ADDR_WIDTH-1:0] acc_addr_b2,
    output logic [ACC_MEM_BLOCKS*DATA_WIDTH-1:0]   acc_wr_data_b2,
    input  logic [ACC_MEM_BLOCKS*DATA_WIDTH-1:0]   acc_rd_data_b2
);

    localparam int CH_W   = $clog2(ACC_CHANNELS);
    localparam int LANE_W = $clog2(STRB_WIDTH);
    localparam int BEAT_W = 17 - LANE_W;       // holds ceil(65535/STRB_WIDTH)
    localparam int WORDS  = DATA_WIDTH/16;

    // Sum of the network-order 16-bit words of one line, with bytes outside the mask zeroed.
    function automatic logic [31:0] beat_sum(input logic [DATA_WIDTH-1:0] d,
                                             input logic [STRB_WIDTH-1:0] m);
        logic [31:0] s;
        logic [7:0]  hi;
        logic [7:0]  lo;
        s = '0;
        for (int j = 0; j < WORDS; j++) begin
            hi = m[2*j]   ? d[16*j +: 8]   : 8'h00;
            lo = m[2*j+1] ? d[16*j+8 +: 8] : 8'h00;
            s  = s + {16'h0, hi, lo};
        end
        return s;
    endfunction

    // 32-bit add with end-around carry.
    function automatic logic [31:0] add_eac(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[31:0] + {31'h0, s[32]};
    endfunction

    function automatic logic [15:0] csum_final(input logic [31:0] a);
        logic [16:0] f1;
        logic [15:0] f2;
        f1 = {1'b0, a[15:0]} + {1'b0, a[31:16]};
        f2 = f1[15:0] + {15'h0, f1[16]};
        return ~f2;
    endfunction

    function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    // Per-channel state.
    logic [PMEM_ADDR_WIDTH-1:0] ch_addr   [ACC_CHANNELS];
    logic [15:0]                ch_len    [ACC_CHANNELS];
    logic [15:0]                ch_result [ACC_CHANNELS];
    logic [15:0]                ch_rem    [ACC_CHANNELS];
    logic [BEAT_W-1:0]          ch_beats  [ACC_CHANNELS];
    logic [ACC_ADDR_WIDTH-1:0]  ch_line   [ACC_CHANNELS];
    logic [PMEM_SEL_BITS-1:0]   ch_blk    [ACC_CHANNELS];
    logic [31:0]                ch_acc    [ACC_CHANNELS];
    logic [ACC_CHANNELS-1:0]    ch_busy;
    logic [ACC_CHANNELS-1:0]    ch_done;
    logic [CH_W-1:0]            rr_ptr;

    // io decode
    logic            wr_hit;
    logic [CH_W-1:0] io_ch;
    logic [2:0]      io_reg;
    logic [ACC_CHANNELS-1:0] start_req;
    logic [31:0]     rd_mux;

    assign wr_hit = io_en && io_wen;
    assign io_ch  = io_addr[5 +: CH_W];
    assign io_reg = io_addr[4:2];

    always_comb begin
        for (int c = 0; c < ACC_CHANNELS; c++)
            start_req[c] = wr_hit && (io_ch == CH_W'(c)) && (io_reg == 3'd2) &&
                           io_strb[0] && io_wr_data[0] && !ch_busy[c];
    end

    // ---- stage p0: round-robin issue ----
    logic                      gnt_vld_p0;
    logic [CH_W-1:0]           gnt_ch_p0;
    logic [CH_W-1:0]           cand_p0;
    logic [PMEM_SEL_BITS-1:0]  gnt_blk_p0;
    logic [STRB_WIDTH-1:0]     mask_p0;

    always_comb begin
        gnt_vld_p0 = 1'b0;
        gnt_ch_p0  = '0;
        cand_p0    = '0;
        // Scanning from the far end means the last hit is the one nearest rr_ptr.
        for (int i = ACC_CHANNELS-1; i >= 0; i--) begin
            cand_p0 = rr_ptr + CH_W'(i);
            if (ch_busy[cand_p0] && (ch_beats[cand_p0] != '0)) begin
                gnt_vld_p0 = 1'b1;
                gnt_ch_p0  = cand_p0;
            end
        end
    end

    assign gnt_blk_p0 = ch_blk[gnt_ch_p0];

    always_comb begin
        if (ch_rem[gnt_ch_p0] >= 16'(STRB_WIDTH))
            mask_p0 = '1;
        else
            mask_p0 = STRB_WIDTH'((32'd1 << ch_rem[gnt_ch_p0][LANE_W-1:0]) - 32'd1);
    end

    always_comb begin
        acc_en_b1   = '0;
        acc_addr_b1 = '0;
        if (gnt_vld_p0) begin
            acc_en_b1[gnt_blk_p0] = 1'b1;
            acc_addr_b1[gnt_blk_p0*ACC_ADDR_WIDTH +: ACC_ADDR_WIDTH] = ch_line[gnt_ch_p0];
        end
    end

    assign acc_wen_b1     = '0;
    assign acc_wr_data_b1 = '0;
    assign acc_en_b2      = '0;
    assign acc_wen_b2     = '0;
    assign acc_addr_b2    = '0;
    assign acc_wr_data_b2 = '0;

    // ---- stage p1: read data returns alongside its tag ----
    logic                      vld_p1;
    logic [CH_W-1:0]           ch_p1;
    logic [PMEM_SEL_BITS-1:0]  blk_p1;
    logic [STRB_WIDTH-1:0]     mask_p1;
    logic [DATA_WIDTH-1:0]     line_p1;
    logic [31:0]               beat_p1;

    assign line_p1 = acc_rd_data_b1[blk_p1*DATA_WIDTH +: DATA_WIDTH];
    assign beat_p1 = beat_sum(line_p1, mask_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            ch_p1   <= '0;
            blk_p1  <= '0;
            mask_p1 <= '0;
            rr_ptr  <= '0;
            ch_busy <= '0;
            ch_done <= '0;
            for (int c = 0; c < ACC_CHANNELS; c++) begin
                ch_addr[c]   <= '0;
                ch_len[c]    <= '0;
                ch_result[c] <= '0;
                ch_rem[c]    <= '0;
                ch_beats[c]  <= '0;
                ch_line[c]   <= '0;
                ch_blk[c]    <= '0;
                ch_acc[c]    <= '0;
            end
        end else begin
            vld_p1  <= gnt_vld_p0;
            ch_p1   <= gnt_ch_p0;
            blk_p1  <= gnt_blk_p0;
            mask_p1 <= mask_p0;
            if (gnt_vld_p0)
                rr_ptr <= gnt_ch_p0 + CH_W'(1);

            for (int c = 0; c < ACC_CHANNELS; c++) begin
                if (gnt_vld_p0 && (gnt_ch_p0 == CH_W'(c))) begin
                    ch_beats[c] <= ch_beats[c] - BEAT_W'(1);
                    ch_line[c]  <= ch_line[c] + ACC_ADDR_WIDTH'(1);
                    ch_rem[c]   <= (ch_rem[c] > 16'(STRB_WIDTH)) ?
                                   ch_rem[c] - 16'(STRB_WIDTH) : 16'd0;
                end

                if (vld_p1 && (ch_p1 == CH_W'(c)))
                    ch_acc[c] <= add_eac(ch_acc[c], beat_p1);

                // Done once every beat has been issued and the last one folded in.
                if (ch_busy[c] && (ch_beats[c] == '0) && !(vld_p1 && (ch_p1 == CH_W'(c)))) begin
                    ch_busy[c]   <= 1'b0;
                    ch_done[c]   <= 1'b1;
                    ch_result[c] <= csum_final(ch_acc[c]);
                end

                if (wr_hit && (io_ch == CH_W'(c)) && !ch_busy[c]) begin
                    if (io_reg == 3'd0)
                        ch_addr[c] <= {PMEM_ADDR_WIDTH'(merge32(32'(ch_addr[c]), io_wr_data, io_strb))
                                          >> LANE_W, LANE_W'(0)};
                    if (io_reg == 3'd1)
                        ch_len[c] <= merge32({16'h0, ch_len[c]}, io_wr_data, io_strb)[15:0];
                end

                if (start_req[c]) begin
                    ch_busy[c]  <= 1'b1;
                    ch_done[c]  <= 1'b0;
                    ch_acc[c]   <= '0;
                    ch_rem[c]   <= ch_len[c];
                    ch_beats[c] <= BEAT_W'(({1'b0, ch_len[c]} + 17'(STRB_WIDTH-1)) >> LANE_W);
                    ch_line[c]  <= ch_addr[c][LANE_W +: ACC_ADDR_WIDTH];
                    ch_blk[c]   <= ch_addr[c][LANE_W+ACC_ADDR_WIDTH +: PMEM_SEL_BITS];
                end
            end
        end
    end

`ifdef ACCEL_CSUM_PERF_EN
    logic [31:0] ch_cycles [ACC_CHANNELS];

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < ACC_CHANNELS; c++)
                ch_cycles[c] <= '0;
        end else begin
            for (int c = 0; c < ACC_CHANNELS; c++) begin
                if (start_req[c])
                    ch_cycles[c] <= '0;
                else if (ch_busy[c])
                    ch_cycles[c] <= sat_inc32(ch_cycles[c]);
            end
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (io_reg)
            3'd0: rd_mux = 32'(ch_addr[io_ch]);
            3'd1: rd_mux = {16'h0, ch_len[io_ch]};
            3'd2: rd_mux = {30'h0, ch_done[io_ch], ch_busy[io_ch]};
            3'd3: rd_mux = {16'h0, ch_result[io_ch]};
`ifdef ACCEL_CSUM_PERF_EN
            3'd4: rd_mux = ch_cycles[io_ch];
`endif
            default: rd_mux = '0;
        endcase
    end

    // Reads sample the registers before any same-edge update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rd_valid <= 1'b0;
            io_rd_data  <= '0;
        end else begin
            io_rd_valid <= io_en && !io_wen;
            if (io_en && !io_wen)
                io_rd_data <= rd_mux;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{io_addr[21:5+CH_W], io_addr[1:0], acc_rd_data_b2};

endmodule

// File: tb/tb_accel_csum_scan.sv
module tb_accel_csum_scan;

    localparam int DW  = 128;
    localparam int SW  = 16;
    localparam int AAW = 12;
    localparam int NB  = 2;
    localparam int R_ADDR = 0, R_LEN = 1, R_CTRL = 2, R_RES = 3, R_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              io_en = 1'b0;
    logic              io_wen = 1'b0;
    logic [3:0]        io_strb = 4'h0;
    logic [21:0]       io_addr = '0;
    logic [31:0]       io_wr_data = '0;
    logic [31:0]       io_rd_data;
    logic              io_rd_valid;
    logic [NB-1:0]     acc_en_b1, acc_en_b2;
    logic [NB*SW-1:0]  acc_wen_b1, acc_wen_b2;
    logic [NB*AAW-1:0] acc_addr_b1, acc_addr_b2;
    logic [NB*DW-1:0]  acc_wr_data_b1, acc_wr_data_b2;
    logic [NB*DW-1:0]  acc_rd_data_b1 = '0;
    logic [NB*DW-1:0]  acc_rd_data_b2 = '0;

    accel_csum_scan dut (
        .clk(clk), .rst_n(rst_n),
        .io_en(io_en), .io_wen(io_wen), .io_strb(io_strb), .io_addr(io_addr),
        .io_wr_data(io_wr_data), .io_rd_data(io_rd_data), .io_rd_valid(io_rd_valid),
        .acc_en_b1(acc_en_b1), .acc_wen_b1(acc_wen_b1), .acc_addr_b1(acc_addr_b1),
        .acc_wr_data_b1(acc_wr_data_b1), .acc_rd_data_b1(acc_rd_data_b1),
        .acc_en_b2(acc_en_b2), .acc_wen_b2(acc_wen_b2), .acc_addr_b2(acc_addr_b2),
        .acc_wr_data_b2(acc_wr_data_b2), .acc_rd_data_b2(acc_rd_data_b2)
    );

    always #5 clk = ~clk;

    // Packet memory: NB blocks of 4096 lines, 1-cycle read latency.
    logic [DW-1:0] mem [NB][4096];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (acc_en_b1[b])
                acc_rd_data_b1[b*DW +: DW] <= mem[b][acc_addr_b1[b*AAW +: AAW]];
    end

    // Read-port monitor, sampled mid-cycle.
    int q_blk[$];
    int q_line[$];
    int q_cyc[$];
    int cyc = 0;
    int onehot_err = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && (acc_en_b1 != '0)) begin
            if ($countones(acc_en_b1) != 1) onehot_err <= onehot_err + 1;
            for (int b = 0; b < NB; b++)
                if (acc_en_b1[b]) begin
                    q_blk.push_back(b);
                    q_line.push_back(int'(acc_addr_b1[b*AAW +: AAW]));
                    q_cyc.push_back(cyc);
                end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RFC 1071 over the byte stream, computed directly from memory.
    function automatic logic [7:0] get_byte(input int unsigned addr, input int i);
        int blk, line;
        blk  = (addr >> 16) & 1;
        line = ((addr >> 4) + (i >> 4)) % 4096;
        return mem[blk][line][8*(i % 16) +: 8];
    endfunction

    function automatic logic [15:0] model_csum(input int unsigned addr, input int len);
        longint unsigned s;
        logic [7:0] hi, lo;
        s = 0;
        for (int i = 0; i < len; i += 2) begin
            hi = get_byte(addr, i);
            lo = (i + 1 < len) ? get_byte(addr, i + 1) : 8'h00;
            s += {hi, lo};
        end
        while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic put_byte(input int unsigned addr, input int i, input logic [7:0] v);
        int blk, line;
        blk  = (addr >> 16) & 1;
        line = ((addr >> 4) + (i >> 4)) % 4096;
        mem[blk][line][8*(i % 16) +: 8] = v;
    endtask

    function automatic logic [21:0] mk_addr(input int ch, input int rg);
        logic [21:0] a;
        a = 22'($urandom) & 22'h3FFF80;
        a[6:5] = ch[1:0];
        a[4:2] = rg[2:0];
        return a;
    endfunction

    task automatic io_wr(input int ch, input int rg, input logic [31:0] d, input logic [3:0] s);
        io_en = 1'b1; io_wen = 1'b1; io_strb = s; io_addr = mk_addr(ch, rg); io_wr_data = d;
        @(posedge clk); #1;
        io_en = 1'b0; io_wen = 1'b0; io_strb = 4'h0;
    endtask

    task automatic io_rd(input int ch, input int rg, output logic [31:0] d);
        io_en = 1'b1; io_wen = 1'b0; io_addr = mk_addr(ch, rg);
        @(posedge clk); #1;
        io_en = 1'b0;
        check("rd_valid", {31'h0, io_rd_valid}, 32'h1);
        d = io_rd_data;
    endtask

    task automatic start_job(input int ch, input int unsigned addr, input int len);
        io_wr(ch, R_ADDR, addr, 4'hF);
        io_wr(ch, R_LEN, len, 4'hF);
        io_wr(ch, R_CTRL, 32'h1, 4'hF);
    endtask

    task automatic wait_done(input int ch);
        logic [31:0] v;
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            io_rd(ch, R_CTRL, v);
            if (v[1]) got = 1'b1;
        end
        check("done_within_budget", {31'h0, got}, 32'h1);
    endtask

    task automatic run_and_check(input string tag, input int ch, input int unsigned addr, input int len);
        logic [31:0] v;
        start_job(ch, addr, len);
        wait_done(ch);
        io_rd(ch, R_RES, v);
        check(tag, v, {16'h0, model_csum(addr, len)});
    endtask

    task automatic clear_mon();
        q_blk.delete(); q_line.delete(); q_cyc.delete();
    endtask

    logic [7:0] ipv4 [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                              8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

    initial begin
        #500_000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int unsigned a;
        int n;

        for (int b = 0; b < NB; b++)
            for (int l = 0; l < 4096; l++)
                mem[b][l] = {$urandom, $urandom, $urandom, $urandom};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_valid", {31'h0, io_rd_valid}, 32'h0);
        check("rst_rd_data", io_rd_data, 32'h0);
        check("rst_en_b1", 32'(acc_en_b1), 32'h0);
        check("rst_addr_b1", 32'(acc_addr_b1), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        io_rd(0, R_CTRL, v);   check("rst_ctrl", v, 32'h0);
        io_rd(2, R_RES, v);    check("rst_result", v, 32'h0);
        @(posedge clk); #1;
        check("rd_valid_drops", {31'h0, io_rd_valid}, 32'h0);

        // ADDR low bits forced to zero, and byte strobes honoured
        io_wr(1, R_ADDR, 32'h0000_0047, 4'hF);
        io_rd(1, R_ADDR, v);   check("addr_align", v, 32'h40);
        io_wr(1, R_ADDR, 32'h1234_AB99, 4'b0010);
        io_rd(1, R_ADDR, v);   check("addr_strb", v, 32'hAB40);
        io_rd(1, 5, v);        check("unmapped_0x14", v, 32'h0);

        // IPv4 header on ch0
        for (int i = 0; i < 20; i++) put_byte(32'h40, i, ipv4[i]);
        clear_mon();
        start_job(0, 32'h40, 20);
        wait_done(0);
        io_rd(0, R_RES, v);    check("ipv4_result", v, 32'hB861);
        check("ipv4_reads", q_blk.size(), 2);

        // LEN=3 odd-byte pad, with random bytes after the payload
        put_byte(32'h300, 0, 8'h01); put_byte(32'h300, 1, 8'h02); put_byte(32'h300, 2, 8'h03);
        start_job(1, 32'h300, 3);
        wait_done(1);
        io_rd(1, R_RES, v);    check("odd_len3", v, 32'hFBFD);

        // LEN=0: no reads. The first read samples the pre-completion value.
        clear_mon();
        start_job(2, 32'h500, 0);
        io_rd(2, R_CTRL, v);   check("len0_same_cycle", v, 32'h1);
        io_rd(2, R_CTRL, v);   check("len0_done", v, 32'h2);
        io_rd(2, R_RES, v);    check("len0_result", v, 32'hFFFF);
        check("len0_no_reads", q_blk.size(), 0);

        // 1-beat latency and CYCLES
        start_job(3, 32'h2000, 16);
        io_rd(3, R_CTRL, v);   check("lat_c1", v, 32'h1);
        io_rd(3, R_CTRL, v);   check("lat_c2", v, 32'h1);
        io_rd(3, R_CTRL, v);   check("lat_c3", v, 32'h1);
        io_rd(3, R_CTRL, v);   check("lat_c4", v, 32'h2);
        io_rd(3, R_RES, v);    check("lat_result", v, {16'h0, model_csum(32'h2000, 16)});
        io_rd(3, R_CYC, v);
`ifdef ACCEL_CSUM_PERF_EN
        check("cycles", v, 32'd3);
`else
        check("cycles_absent", v, 32'd0);
`endif

        // Four channels, 4 beats each, started back to back
        for (int c = 0; c < 4; c++) begin
            io_wr(c, R_ADDR, c << 12, 4'hF);
            io_wr(c, R_LEN, 64, 4'hF);
        end
        clear_mon();
        for (int c = 0; c < 4; c++) io_wr(c, R_CTRL, 32'h1, 4'hF);
        for (int c = 0; c < 4; c++) begin
            wait_done(c);
            io_rd(c, R_RES, v);
            check("rr_result", v, {16'h0, model_csum(c << 12, 64)});
        end
        check("rr_read_count", q_blk.size(), 16);
        n = 0;
        for (int i = 0; i < q_line.size(); i++) begin
            if ((q_line[i] >> 8) != (i % 4)) n++;
            if (q_cyc[i] != q_cyc[0] + i) n++;
        end
        check("rr_order", n, 0);

        // Wrap from the last line of block 0, with LEN written while busy
        clear_mon();
        start_job(2, 32'hFFF0, 32);
        io_wr(2, R_LEN, 32'h5, 4'hF);
        wait_done(2);
        io_rd(2, R_LEN, v);    check("len_busy_ignored", v, 32'd32);
        io_rd(2, R_RES, v);    check("wrap_result", v, {16'h0, model_csum(32'hFFF0, 32)});
        check("wrap_reads", q_blk.size(), 2);
        if (q_blk.size() == 2) begin
            check("wrap_line0", q_line[0], 4095);
            check("wrap_line1", q_line[1], 0);
            check("wrap_blk", q_blk[0] + q_blk[1], 0);
        end

        // Random jobs across channels and both blocks
        for (int k = 0; k < 8; k++) begin
            a = $urandom & 32'h3FFF0;
            run_and_check("rand_result", $urandom_range(0, 3), a, $urandom_range(1, 300));
        end
        run_and_check("block1_result", 0, 32'h1_0120, 45);

        // Reset mid-job
        start_job(1, 32'h100, 200);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("abort_en_b1", 32'(acc_en_b1), 32'h0);
        check("abort_rd_valid", {31'h0, io_rd_valid}, 32'h0);
        check("abort_rd_data", io_rd_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        @(posedge clk); #1;
        check("abort_no_reads", q_blk.size(), 0);
        io_rd(1, R_CTRL, v);   check("abort_ctrl", v, 32'h0);
        io_rd(1, R_LEN, v);    check("abort_len", v, 32'h0);
        run_and_check("post_reset_result", 1, 32'h3450, 77);

        check("en_onehot", onehot_err, 0);
        check("b2_tied", {28'h0, |acc_en_b2, |acc_wen_b2, |acc_addr_b2, |acc_wr_data_b2}, 32'h0);
        check("b1_wr_tied", {30'h0, |acc_wen_b1, |acc_wr_data_b1}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
